// File: rtl/op_vec_fifo.sv
// Operand-vector FIFO feeding the shared-expression stage.
// First-word-fall-through. Fields are zeroed while the buffer is empty.
module op_vec_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [4:0]    in_vec,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          d,
  output logic          e,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;

  assign in_ready  = !rst && !flush && (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign {a, b, c, d, e} = out_valid ? mem[rp] : 5'b0;

  // push is already gated by rst and flush through in_ready
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_vec;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_op_vec_fifo.sv
// Directed and random checks for op_vec_fifo (DEPTH = 4).
module tb_op_vec_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [4:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       a, b, c, d, e;
  logic [2:0] count;
  logic [4:0] vec_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [4:0] q[$];
  logic [4:0] exp_head;

  assign vec_out = {a, b, c, d, e};

  always #5 clk = ~clk;

  op_vec_fifo #(.DEPTH(4), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .count     (count)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_one(input logic [4:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;

    // reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_count", 8'(count), 8'd0);
      check("rst_ovalid", 8'(out_valid), 8'd0);
      check("rst_vec", 8'(vec_out), 8'h00);
      check("rst_iready", 8'(in_ready), 8'd0);
    end
    rst = 1'b0;
    settle();
    check("post_rst_iready", 8'(in_ready), 8'd1);

    // single vector, then one pop
    push_one(5'b10110);
    settle();
    check("single_vec", 8'(vec_out), 8'h16);
    check("single_a", 8'(a), 8'd1);
    check("single_e", 8'(e), 8'd0);
    check("single_ovalid", 8'(out_valid), 8'd1);
    check("single_count", 8'(count), 8'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    settle();
    check("single_pop_count", 8'(count), 8'd0);
    check("single_pop_vec", 8'(vec_out), 8'h00);
    check("single_pop_ovalid", 8'(out_valid), 8'd0);

    // fill, blocked fifth push, pop two, push across the wrap
    for (int i = 1; i <= 4; i++) push_one(5'(i));
    in_valid = 1'b1;
    in_vec   = 5'h05;
    settle();
    check("full_count", 8'(count), 8'd4);
    check("full_iready", 8'(in_ready), 8'd0);
    tick();
    in_valid = 1'b0;
    settle();
    check("full_push_ignored", 8'(count), 8'd4);
    check("full_head", 8'(vec_out), 8'h01);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    settle();
    check("pop2_count", 8'(count), 8'd2);
    push_one(5'h06);
    push_one(5'h07);
    settle();
    check("wrap_count", 8'(count), 8'd4);
    out_ready = 1'b1;
    check("drain0", 8'(vec_out), 8'h03); tick();
    check("drain1", 8'(vec_out), 8'h04); tick();
    check("drain2", 8'(vec_out), 8'h06); tick();
    check("drain3", 8'(vec_out), 8'h07); tick();
    out_ready = 1'b0;
    settle();
    check("drain_count", 8'(count), 8'd0);

    // simultaneous push and pop at count 2
    push_one(5'h10);
    push_one(5'h11);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_vec = 5'(5'h12 + k);
      settle();
      check("pp_head", 8'(vec_out), 8'(8'h10 + k));
      check("pp_count", 8'(count), 8'd2);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    settle();
    check("pp_final_count", 8'(count), 8'd2);
    check("pp_final_head", 8'(vec_out), 8'h1A);

    // push plus pop at full: only the pop happens
    push_one(5'h1C);
    push_one(5'h1D);
    in_valid  = 1'b1;
    in_vec    = 5'h1E;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    check("fullpp_count", 8'(count), 8'd3);
    check("fullpp_h0", 8'(vec_out), 8'h1B); tick();
    check("fullpp_h1", 8'(vec_out), 8'h1C); tick();
    check("fullpp_h2", 8'(vec_out), 8'h1D); tick();
    out_ready = 1'b0;
    settle();
    check("fullpp_empty", 8'(count), 8'd0);

    // flush at count 3 with a push attempt
    push_one(5'h01); push_one(5'h02); push_one(5'h03);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 5'h04;
    settle();
    check("flush_iready", 8'(in_ready), 8'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    settle();
    check("flush_count", 8'(count), 8'd0);
    check("flush_ovalid", 8'(out_valid), 8'd0);
    check("flush_vec", 8'(vec_out), 8'h00);
    push_one(5'h05);
    settle();
    check("flush_next_head", 8'(vec_out), 8'h05);
    check("flush_next_count", 8'(count), 8'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // same sequence with rst
    push_one(5'h01); push_one(5'h02); push_one(5'h03);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_vec   = 5'h04;
    settle();
    check("mrst_iready", 8'(in_ready), 8'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    settle();
    check("mrst_count", 8'(count), 8'd0);
    check("mrst_ovalid", 8'(out_valid), 8'd0);
    check("mrst_vec", 8'(vec_out), 8'h00);
    check("mrst_iready_after", 8'(in_ready), 8'd1);
    push_one(5'h05);
    settle();
    check("mrst_next_head", 8'(vec_out), 8'h05);
    check("mrst_next_count", 8'(count), 8'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // random traffic against a queue model, starting empty
    q.delete();
    for (int n = 0; n < 2000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_vec    = 5'($urandom_range(0, 31));
      settle();
      exp_head = (q.size() != 0) ? q[0] : 5'h00;
      check("rnd_count", 8'(count), 8'(q.size()));
      check("rnd_count_max", 8'(count <= 3'd4), 8'd1);
      check("rnd_iready", 8'(in_ready), 8'(q.size() != 4));
      check("rnd_ovalid", 8'(out_valid), 8'(q.size() != 0));
      check("rnd_vec", 8'(vec_out), 8'(exp_head));
      if (q.size() == 4) begin
        if (out_ready) void'(q.pop_front());
      end else begin
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid) q.push_back(in_vec);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_vec_fifo.md
# op_vec_fifo

Operand-vector buffer that sits directly upstream of the shared-expression logic stage. It accepts 5-bit operand vectors {a,b,c,d,e} over a valid/ready handshake, stores up to DEPTH of them in order, and presents the oldest one on dedicated single-bit outputs a..e that wire straight into the combinational stage's inputs. It decouples the operand producer from the consumer that samples q.

## Interface
- DEPTH, 4: number of stored vectors; power of two, at least 2.
- CW, 3: width of `count`; equals clog2(DEPTH)+1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stored vectors.
- in_valid  in  1  producer has a vector on in_vec.
- in_vec  in  5  operand vector: bit4=a, bit3=b, bit2=c, bit1=d, bit0=e.
- in_ready  out  1  buffer can accept a vector this cycle.
- out_valid  out  1  a..e hold a valid vector.
- out_ready  in  1  consumer takes the current vector this cycle.
- a, b, c, d, e  out  1 each  fields of the oldest stored vector.
- count  out  CW  number of stored vectors, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry register array with a write pointer `wp` and a read pointer `rp`, each clog2(DEPTH) bits wide, plus `count`.
- Pointers wrap modulo DEPTH with natural binary overflow. No special-case logic is used at the wrap.
- push = in_valid & in_ready. The vector is written to mem[wp], and wp increments.
- pop = out_valid & out_ready. rp increments.
- count updates as follows:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- in_ready = !rst & !flush & (count != DEPTH).
- out_valid = (count != 0). This is combinational from registered count.
- The read is first-word-fall-through: {a,b,c,d,e} = mem[rp] when count != 0.
- When count == 0, all five outputs are forced to 0. Stale data is never exposed.
- Full (count == DEPTH):
  - in_ready = 0.
  - A simultaneous pop does not enable a same-cycle push. There is no pass-through.
- Empty (count == 0):
  - out_valid = 0, so out_ready is ignored.
  - A pushed vector becomes visible on a..e the next cycle. There is no bypass.
- Push and pop in the same cycle with 0 < count < DEPTH: both take effect.
- Data ordering is strictly FIFO. No vector is dropped or duplicated.
- A push attempted while in_ready = 0 is ignored. Holding in_vec stable is the producer's responsibility.
- flush, when high at the edge:
  - wp, rp and count go to 0.
  - It overrides any push or pop in the same cycle.
  - Memory contents are not cleared, but they are masked because count = 0.
- rst has priority over flush and over both handshakes.

## Timing
- Reset state (after the first edge with rst = 1): wp = 0, rp = 0, count = 0, out_valid = 0, a..e = 0.
- in_ready is 0 throughout any cycle with rst = 1, and goes to 1 in the first cycle after rst falls.
- Latency from accepted input to visible output is 1 cycle when the buffer is empty.
- Sustained throughput is 1 vector/cycle with in_valid = out_ready = 1 continuously and 0 < count < DEPTH.
- Outputs a..e and out_valid change only after clock edges. They are combinational only from registers, never from in_* inputs.
- in_ready depends combinationally on rst and flush, and otherwise only on registered count.
- Reset or flush mid-stream: the next cycle shows count = 0, out_valid = 0 and a..e = 0. Vectors held in the buffer are discarded.
- Memory is written only on push. No reset of the array is required.

## Test plan
- Reset/idle:
  - Stimulus: hold rst = 1 for 2 cycles, then release.
  - Required: count = 0, out_valid = 0, a..e = 0 while rst is high; in_ready = 0 during reset and 1 the cycle after rst falls.
- Single vector:
  - Stimulus: push in_vec = 5'b10110, with out_ready = 0.
  - Required: next cycle a=1, b=0, c=1, d=1, e=0; out_valid = 1; count = 1.
  - Then pulse out_ready for 1 cycle. Required: count = 0 and a..e = 0.
- Fill and wrap:
  - Stimulus: with DEPTH = 4, push 5'h01, 5'h02, 5'h03, 5'h04.
  - Required: count = 4 and in_ready = 0; a fifth push of 5'h05 is ignored.
  - Then pop 2 and push 5'h06, 5'h07 (pointers wrap). Required: drain order 03, 04, 06, 07.
- Simultaneous push/pop:
  - At count = 2: push plus pop for 10 cycles. Required: count stays 2 and output order matches input order.
  - At count = 4: push plus pop. Required: only the pop occurs and count = 3.
- Flush and mid-operation reset:
  - Stimulus: at count = 3, assert flush together with in_valid = 1. Required: next cycle count = 0, out_valid = 0, and the pushed vector is discarded.
  - Stimulus: repeat the sequence with rst instead of flush. Required: identical result.
- Random stress:
  - Stimulus: 2000 cycles of random in_valid/out_ready, checked against a reference queue model.
  - Required: zero ordering or count mismatches, count never exceeds 4, and a..e = 0 whenever out_valid = 0.
